// File: rtl/pinball_game_sequencer.sv
// Game-level sequencer for the pinball scoring path: ball play FSM, ball counting,
// switch edge detection and fixed-priority serialisation of target hits onto a valid/ready stream.
module pinball_game_sequencer #(
  parameter int BALLS    = 5,
  parameter int BALL_W   = 3,
  parameter int SCORE_W  = 16,
  parameter int AMT_GO   = 100,
  parameter int AMT_BOP  = 300,
  parameter int AMT_WHAM = 500,
  parameter int AMT_BASH = 800,
  parameter int AMT_WIPE = 1000
) (
  input  logic               CLK,
  input  logic               INIT,
  input  logic               GO_HIT,
  input  logic               BOP_HIT,
  input  logic               WHAM_HIT,
  input  logic               BASH_HIT,
  input  logic               WIPE_OUT_HIT,
  input  logic               START_BALL,
  input  logic               DRAIN,
  input  logic               TILT,
  output logic               upd_valid,
  input  logic               upd_ready,
  output logic               upd_sub,
  output logic [SCORE_W-1:0] upd_amount,
  output logic [BALL_W-1:0]  ball_count,
  output logic [2:0]         state,
  output logic               hit_dropped,
  output logic               game_over
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READY  = 3'd1,
    S_PLAY   = 3'd2,
    S_TILTED = 3'd3,
    S_END    = 3'd4
  } state_e;

  // Target bit order doubles as priority order: bit 0 (GO) wins, bit 4 (WIPE_OUT) loses.
  function automatic logic [4:0] pick_winner(input logic [4:0] req);
    logic [4:0] gnt;
    gnt = 5'b00000;
    if (req[0]) begin
      gnt = 5'b00001;
    end else if (req[1]) begin
      gnt = 5'b00010;
    end else if (req[2]) begin
      gnt = 5'b00100;
    end else if (req[3]) begin
      gnt = 5'b01000;
    end else if (req[4]) begin
      gnt = 5'b10000;
    end else begin
      gnt = 5'b00000;
    end
    return gnt;
  endfunction

  function automatic logic [SCORE_W-1:0] amount_of(input logic [4:0] gnt);
    logic [SCORE_W-1:0] amt;
    case (gnt)
      5'b00001: amt = SCORE_W'(AMT_GO);
      5'b00010: amt = SCORE_W'(AMT_BOP);
      5'b00100: amt = SCORE_W'(AMT_WHAM);
      5'b01000: amt = SCORE_W'(AMT_BASH);
      5'b10000: amt = SCORE_W'(AMT_WIPE);
      default:  amt = {SCORE_W{1'b0}};
    endcase
    return amt;
  endfunction

  logic [7:0]         sw_in_s;
  logic [7:0]         sw_q;
  logic [7:0]         sw_prev_q;
  logic [7:0]         ev_s;
  logic [4:0]         hit_ev_s;
  logic               start_ev_s;
  logic               drain_ev_s;
  logic               tilt_ev_s;

  state_e             state_q, state_d, drain_target_s;
  logic [BALL_W-1:0]  ball_count_q, ball_count_d;
  logic [4:0]         pend_q, pend_d;
  logic [4:0]         grant_s;
  logic [4:0]         pend_left_s;
  logic               load_s;
  logic               drop_q, drop_d;
  logic               valid_q, valid_d;
  logic               sub_q, sub_d;
  logic [SCORE_W-1:0] amount_q, amount_d;
  logic               game_over_q, game_over_d;

  assign sw_in_s    = {TILT, DRAIN, START_BALL, WIPE_OUT_HIT, BASH_HIT, WHAM_HIT, BOP_HIT, GO_HIT};
  assign ev_s       = sw_q & ~sw_prev_q;
  assign hit_ev_s   = ev_s[4:0];
  assign start_ev_s = ev_s[5];
  assign drain_ev_s = ev_s[6];
  assign tilt_ev_s  = ev_s[7];

  assign drain_target_s = (ball_count_q == {BALL_W{1'b0}}) ? S_END : S_READY;

  // Switch capture and one-cycle history for rising-edge detection.
  always_ff @(posedge CLK or negedge INIT) begin
    if (!INIT) begin
      sw_q      <= 8'h00;
      sw_prev_q <= 8'h00;
    end else begin
      sw_q      <= sw_in_s;
      sw_prev_q <= sw_q;
    end
  end

  // Ball-play state transitions and ball counting.
  always_comb begin
    state_d      = state_q;
    ball_count_d = ball_count_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_READY;
      end
      S_READY: begin
        if (ball_count_q == {BALL_W{1'b0}}) begin
          state_d = S_END;
        end else if (start_ev_s) begin
          state_d      = S_PLAY;
          ball_count_d = ball_count_q - BALL_W'(1);
        end else begin
          state_d = S_READY;
        end
      end
      S_PLAY: begin
        if (tilt_ev_s) begin
          state_d = S_TILTED;
        end else if (drain_ev_s) begin
          state_d = drain_target_s;
        end else begin
          state_d = S_PLAY;
        end
      end
      S_TILTED: begin
        if (drain_ev_s) begin
          state_d = drain_target_s;
        end else begin
          state_d = S_TILTED;
        end
      end
      S_END: begin
        state_d = S_END;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    game_over_d = (state_d == S_END);
  end

  // Pending latches, drop detection and the single-entry issue slot.
  always_comb begin
    load_s      = (~valid_q | upd_ready) & (state_q == S_PLAY) & (|pend_q);
    grant_s     = load_s ? pick_winner(pend_q) : 5'b00000;
    pend_left_s = pend_q & ~grant_s;
    pend_d      = pend_left_s;
    drop_d      = drop_q;
    valid_d     = valid_q;
    sub_d       = sub_q;
    amount_d    = amount_q;

    if (state_q == S_PLAY) begin
      drop_d = drop_q | (|(hit_ev_s & pend_left_s));
      pend_d = pend_left_s | hit_ev_s;
    end else begin
      pend_d = pend_left_s;
    end

    if (state_d == S_TILTED) begin
      pend_d = 5'b00000;
    end else begin
      pend_d = pend_d;
    end

    // An offer is never withdrawn; it only retires through a transfer.
    if (load_s) begin
      valid_d  = 1'b1;
      sub_d    = grant_s[4];
      amount_d = amount_of(grant_s);
    end else if (valid_q & upd_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Control and datapath registers.
  always_ff @(posedge CLK or negedge INIT) begin
    if (!INIT) begin
      state_q      <= S_IDLE;
      ball_count_q <= BALL_W'(BALLS);
      pend_q       <= 5'b00000;
      drop_q       <= 1'b0;
      valid_q      <= 1'b0;
      sub_q        <= 1'b0;
      amount_q     <= {SCORE_W{1'b0}};
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ball_count_q <= ball_count_d;
      pend_q       <= pend_d;
      drop_q       <= drop_d;
      valid_q      <= valid_d;
      sub_q        <= sub_d;
      amount_q     <= amount_d;
      game_over_q  <= game_over_d;
    end
  end

  assign upd_valid   = valid_q;
  assign upd_sub     = sub_q;
  assign upd_amount  = amount_q;
  assign ball_count  = ball_count_q;
  assign state       = state_q;
  assign hit_dropped = drop_q;
  assign game_over   = game_over_q;

endmodule

// File: tb/tb_pinball_game_sequencer.sv
// Bench for pinball_game_sequencer: a rule-level game model checked every cycle,
// plus literal expectations along a directed play script.
module tb_pinball_game_sequencer;

  logic        CLK = 1'b0;
  logic        INIT = 1'b0;
  logic [7:0]  sw = 8'h00;   // 0 GO,1 BOP,2 WHAM,3 BASH,4 WIPE,5 START,6 DRAIN,7 TILT
  logic        upd_ready = 1'b0;
  logic        upd_valid, upd_sub, hit_dropped, game_over;
  logic [15:0] upd_amount;
  logic [2:0]  ball_count, state;

  int total = 0;
  int bad   = 0;

  localparam logic [7:0] M_GO = 8'h01, M_BOP = 8'h02, M_WHAM = 8'h04, M_BASH = 8'h08,
                         M_WIPE = 8'h10, M_START = 8'h20, M_DRAIN = 8'h40, M_TILT = 8'h80;

  always #5 CLK = ~CLK;

  pinball_game_sequencer dut (
    .CLK(CLK), .INIT(INIT),
    .GO_HIT(sw[0]), .BOP_HIT(sw[1]), .WHAM_HIT(sw[2]), .BASH_HIT(sw[3]), .WIPE_OUT_HIT(sw[4]),
    .START_BALL(sw[5]), .DRAIN(sw[6]), .TILT(sw[7]),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_sub(upd_sub), .upd_amount(upd_amount),
    .ball_count(ball_count), .state(state), .hit_dropped(hit_dropped), .game_over(game_over)
  );

  // Game model: states 0 idle,1 ready,2 play,3 tilted,4 end.
  int       m_state = 0;
  int       m_balls = 5;
  bit [4:0] m_pend  = 5'b00000;
  bit       m_valid = 1'b0;
  bit       m_sub   = 1'b0;
  int       m_amt   = 0;
  bit       m_drop  = 1'b0;
  bit [7:0] h1 = 8'h00, h2 = 8'h00;
  int       amt_tab [5] = '{100, 300, 500, 800, 1000};

  always @(posedge CLK or negedge INIT) begin : model_p
    int       old, w;
    bit [7:0] ev;
    if (!INIT) begin
      m_state = 0; m_balls = 5; m_pend = 5'b00000; m_valid = 1'b0;
      m_sub = 1'b0; m_amt = 0; m_drop = 1'b0; h1 = 8'h00; h2 = 8'h00;
    end else begin
      old = m_state;
      ev  = h1 & ~h2;
      h2  = h1;
      h1  = sw;
      if ((!m_valid || upd_ready) && old == 2 && m_pend != 5'b00000) begin
        w = 0;
        for (int i = 4; i >= 0; i--) if (m_pend[i]) w = i;
        m_valid = 1'b1;
        m_amt   = amt_tab[w];
        m_sub   = (w == 4);
        m_pend[w] = 1'b0;
      end else if (m_valid && upd_ready) begin
        m_valid = 1'b0;
      end
      if (old == 2) begin
        for (int i = 0; i < 5; i++) begin
          if (ev[i]) begin
            if (m_pend[i]) m_drop = 1'b1;
            else m_pend[i] = 1'b1;
          end
        end
      end
      case (old)
        0: m_state = 1;
        1: if (m_balls == 0) m_state = 4;
           else if (ev[5]) begin m_state = 2; m_balls = m_balls - 1; end
        2: if (ev[7]) begin m_state = 3; m_pend = 5'b00000; end
           else if (ev[6]) m_state = (m_balls == 0) ? 4 : 1;
        3: if (ev[6]) m_state = (m_balls == 0) ? 4 : 1;
        default: m_state = m_state;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("m_valid", {31'd0, upd_valid}, {31'd0, m_valid});
    if (m_valid) begin
      chk("m_amount", {16'd0, upd_amount}, m_amt);
      chk("m_sub", {31'd0, upd_sub}, {31'd0, m_sub});
    end
    chk("m_balls", {29'd0, ball_count}, m_balls);
    chk("m_state", {29'd0, state}, m_state);
    chk("m_dropped", {31'd0, hit_dropped}, {31'd0, m_drop});
    chk("m_game_over", {31'd0, game_over}, {31'd0, m_state == 4});
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge CLK);
      compare_model();
    end
  endtask

  task automatic pulse(input logic [7:0] m);
    sw = sw | m;
    tick(1);
    sw = sw & ~m;
  endtask

  task automatic offer(input string name, input int v, input int amt, input int sub);
    chk({name, "_valid"}, {31'd0, upd_valid}, v);
    if (v != 0) begin
      chk({name, "_amount"}, {16'd0, upd_amount}, amt);
      chk({name, "_sub"}, {31'd0, upd_sub}, sub);
    end
  endtask

  initial begin
    // Reset and first ball
    tick(3);
    chk("rst_state", {29'd0, state}, 0);
    chk("rst_balls", {29'd0, ball_count}, 5);
    chk("rst_valid", {31'd0, upd_valid}, 0);
    chk("rst_drop", {31'd0, hit_dropped}, 0);
    INIT = 1'b1;
    tick(1);
    chk("ready_state", {29'd0, state}, 1);
    pulse(M_START);
    tick(1);
    chk("play_state", {29'd0, state}, 2);
    chk("play_balls", {29'd0, ball_count}, 4);
    chk("play_valid", {31'd0, upd_valid}, 0);

    // Simultaneous GO, BASH, WIPE_OUT with ready held high
    upd_ready = 1'b1;
    pulse(M_GO | M_BASH | M_WIPE);
    tick(2); offer("go", 1, 100, 0);
    tick(1); offer("bash", 1, 800, 0);
    tick(1); offer("wipe", 1, 1000, 1);
    tick(1); offer("idle1", 0, 0, 0);
    chk("drop0", {31'd0, hit_dropped}, 0);

    // BOP stall, re-hit while offered, then two transfers
    upd_ready = 1'b0;
    pulse(M_BOP);
    tick(2); offer("bop1", 1, 300, 0);
    pulse(M_BOP);
    tick(1); offer("bop_hold", 1, 300, 0);
    chk("drop_still0", {31'd0, hit_dropped}, 0);
    upd_ready = 1'b1;
    tick(1); offer("bop2", 1, 300, 0);
    tick(1); offer("idle2", 0, 0, 0);
    chk("drop_after2", {31'd0, hit_dropped}, 0);

    // Third BOP while pending and slot stalled -> dropped
    upd_ready = 1'b0;
    pulse(M_BOP); tick(1);
    pulse(M_BOP); tick(1);
    pulse(M_BOP); tick(1);
    chk("drop1", {31'd0, hit_dropped}, 1);
    offer("bop_stall", 1, 300, 0);
    upd_ready = 1'b1;
    tick(3);
    offer("idle3", 0, 0, 0);

    // Tilt with WHAM offered and another WHAM pending
    upd_ready = 1'b0;
    pulse(M_WHAM); tick(1);
    pulse(M_WHAM); tick(1);
    offer("wham", 1, 500, 0);
    pulse(M_TILT); tick(1);
    chk("tilt_state", {29'd0, state}, 3);
    offer("wham_kept", 1, 500, 0);
    upd_ready = 1'b1;
    tick(1); offer("wham_done", 0, 0, 0);
    pulse(M_GO); tick(3);
    offer("tilt_ignore", 0, 0, 0);
    pulse(M_DRAIN); tick(1);
    chk("tilt_drain", {29'd0, state}, 1);
    chk("tilt_balls", {29'd0, ball_count}, 4);
    pulse(M_START); tick(4);
    offer("pend_cleared", 0, 0, 0);
    chk("ball2_balls", {29'd0, ball_count}, 3);

    // Remaining balls to game over
    for (int b = 0; b < 3; b++) begin
      pulse(M_DRAIN); tick(1);
      pulse(M_START); tick(1);
    end
    chk("last_ball_state", {29'd0, state}, 2);
    chk("last_ball_count", {29'd0, ball_count}, 0);
    pulse(M_DRAIN); tick(1);
    chk("end_state", {29'd0, state}, 4);
    chk("end_go", {31'd0, game_over}, 1);
    pulse(M_START); tick(2);
    chk("end_stays", {29'd0, state}, 4);
    chk("end_balls", {29'd0, ball_count}, 0);

    // Asynchronous reset with an update outstanding
    INIT = 1'b0; tick(2);
    INIT = 1'b1; tick(1);
    pulse(M_START); tick(1);
    upd_ready = 1'b0;
    pulse(M_GO); tick(2);
    offer("pre_rst", 1, 100, 0);
    upd_ready = 1'b1;
    #2 INIT = 1'b0;
    #1;
    chk("arst_valid", {31'd0, upd_valid}, 0);
    chk("arst_balls", {29'd0, ball_count}, 5);
    chk("arst_state", {29'd0, state}, 0);
    tick(2);
    INIT = 1'b1;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pinball_game_sequencer.md
Name: pinball_game_sequencer

Overview:
Game-level controller for the pinball scoring datapath. It sequences ball play (start, in play, drain, tilt, game over) and tracks remaining balls. It detects target hits and serialises simultaneous hits through a fixed-priority arbiter into a single valid/ready score-update stream consumed by the score accumulator. The block sits between the playfield switch inputs and the score/display logic.

Parameters:
BALLS, 5, balls per game loaded into ball_count at reset
BALL_W, 3, width of ball_count
SCORE_W, 16, width of upd_amount
AMT_GO, 100, points added for GO target
AMT_BOP, 300, points added for BOP target
AMT_WHAM, 500, points added for WHAM target
AMT_BASH, 800, points added for BASH target
AMT_WIPE, 1000, points subtracted for WIPE_OUT target

Ports:
CLK  in  1  system clock, rising edge
INIT  in  1  asynchronous active-low reset
GO_HIT, BOP_HIT, WHAM_HIT, BASH_HIT, WIPE_OUT_HIT  in  1 each  target switch levels, synchronous to CLK
START_BALL  in  1  plunger/launch level
DRAIN  in  1  ball-lost switch level
TILT  in  1  tilt switch level
upd_valid  out  1  score update offered
upd_ready  in  1  score unit accepts update
upd_sub  out  1  1 = subtract upd_amount, 0 = add
upd_amount  out  SCORE_W  update magnitude
ball_count  out  BALL_W  balls remaining, not yet launched
state  out  3  FSM state encoding
hit_dropped  out  1  sticky: a hit was lost because its target was already pending
game_over  out  1  high in S_END

Behaviour:
- Reset (INIT=0, async): state=S_IDLE, ball_count=BALLS, upd_valid=0, upd_sub=0, upd_amount=0, pending=0, hit_dropped=0, edge-detect history=0.
- Edge detection: each switch input is registered. An event is in & ~prev, one cycle after the level rises. Levels that stay high do not repeat events.
- State encoding: S_IDLE=0, S_READY=1, S_PLAY=2, S_TILTED=3, S_END=4.
- S_IDLE → S_READY on the first clock after reset.
- S_READY: on a START_BALL event, go to S_PLAY and decrement ball_count on the same edge. If ball_count==0 in S_READY, go to S_END instead. Hits are ignored.
- S_PLAY:
  - DRAIN event: go to S_END if ball_count==0, else S_READY.
  - TILT event: go to S_TILTED. TILT has priority over DRAIN in the same cycle.
  - START_BALL events are ignored.
- S_TILTED: pending is cleared on entry, and all hit events are ignored. A DRAIN event exits with the same rule as S_PLAY.
- S_END: terminal until INIT. game_over=1.
- Pending latches, one per target:
  - Set by a hit event only in S_PLAY.
  - A hit event on an already-pending target sets hit_dropped (sticky until reset) and is otherwise discarded.
- Issue slot:
  - Loads when (upd_valid==0 or upd_ready==1), state==S_PLAY, and pending!=0.
  - Fixed priority: GO > BOP > WHAM > BASH > WIPE_OUT.
  - The winner's pending bit is cleared on the same edge. If a new event for that target arrives on that edge, the bit stays set.
  - Latency: hit level rises at edge N, event is seen, pending is set at edge N+1, upd_valid is high after edge N+2 if no contention.
- Handshake rules:
  - A transfer occurs on an edge with upd_valid & upd_ready.
  - While upd_valid=1 and upd_ready=0, upd_amount and upd_sub hold stable.
  - upd_valid drops after a transfer when nothing new loads.
  - Back-to-back transfers (one per cycle) are allowed when upd_ready is held high.
- Update values: WIPE_OUT gives upd_sub=1, upd_amount=AMT_WIPE; all others give upd_sub=0 and their AMT_*. The block does no clamping; the score unit saturates subtraction at 0.
- Tilt/drain/end with an update outstanding: the offered update is not withdrawn and completes when upd_ready rises. No new loads occur outside S_PLAY.
- Reset mid-game: all state returns to reset values immediately, including an outstanding upd_valid.

Test Plan:
- Reset, one clock, START_BALL pulse → S_READY then S_PLAY; ball_count 5→4; upd_valid=0.
- In S_PLAY with upd_ready=1, raise GO, BASH and WIPE_OUT on the same cycle → three consecutive transfers: (0,100), (0,800), (1,1000); hit_dropped=0.
- upd_ready=0, BOP hit, then BOP released and hit again before acceptance → upd_valid holds (0,300) stable; second hit stays pending; ready=1 gives two 300 transfers; hit_dropped=0. A third BOP hit while pending and while the issue slot is still stalled → hit_dropped=1.
- TILT with WHAM pending and a 500 update offered under ready=0 → state=S_TILTED, pending cleared, 500 still transfers when ready=1, later hits ignored; DRAIN → S_READY.
- Play through five balls (START_BALL then DRAIN each) → ball_count 0; after the fifth DRAIN, state=S_END, game_over=1; further START_BALL has no effect.
- Assert INIT low mid-transfer in S_PLAY → upd_valid=0, ball_count=5, state=S_IDLE asynchronously, without waiting for a clock edge.
